// File: rtl/mem_arbiter.sv
// mem_arbiter: memory-side responder for the core's split instruction/data
// interface. It serialises fetches and loads/stores onto one single-port,
// word-wide RAM port and answers with one-cycle ihit/dhit pulses.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When it is defined, a wait
// counter aborts a RAM access that stalls for TIMEOUT cycles and flags the
// response with bus_err. When it is undefined, the arbiter waits
// indefinitely and bus_err stays 0.
//
// Ports:
//   clk, nrst             clock, asynchronous active-low reset
//   imem_ren/imem_addr    fetch request (held until ihit)
//   ihit/imem_load        fetch-complete pulse and fetched word
//   dmem_ren/dmem_wen     load/store request
//   dmem_addr/dmem_width  byte address and access width ([2] is ignored)
//   dmem_store            lane-shifted store data
//   dhit/dmem_load        load/store-complete pulse and raw RAM word
//   ram_*                 single-port RAM request/response
//   bus_err               abort pulse, coincident with ihit/dhit
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        imem_ren,
  input  logic [31:0] imem_addr,
  output logic        ihit,
  output logic [31:0] imem_load,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [2:0]  dmem_width,
  input  logic [31:0] dmem_store,
  output logic        dhit,
  output logic [31:0] dmem_load,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_byteen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, DREQ, IREQ, DRESP, IRESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] load_q, load_d;
  logic        err_q, err_d;
  logic [3:0]  dbe;
  logic        in_req;
  logic        tmo;

  // The counter has to be able to reach TIMEOUT-1.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 2");
  end

  // The unsigned flag and the fetch byte offset do not affect the RAM access.
  logic unused_ok;
  assign unused_ok = ^{dmem_width[2], imem_addr[1:0]};

  assign in_req = (state_q == DREQ) || (state_q == IREQ);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wait_q;

  // REQ states are only entered from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                   wait_q <= '0;
    else if (state_q == IDLE)    wait_q <= '0;
    else if (in_req && !ram_ready) wait_q <= wait_q + 1'b1;
  end

  assign tmo = in_req && !ram_ready && (wait_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // Byte-lane enables; misaligned low address bits are simply masked.
  always_comb begin
    dbe = 4'b1111;
    case (dmem_width[1:0])
      2'b00:   dbe = 4'b0001 << dmem_addr[1:0];
      2'b01:   dbe = 4'b0011 << {dmem_addr[1], 1'b0};
      default: dbe = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      req_q   <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    load_d  = load_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Data wins over fetch; ren+wen together counts as a store.
        if (dmem_ren || dmem_wen) begin
          state_d     = DREQ;
          req_d.addr  = {dmem_addr[31:2], 2'b00};
          req_d.wdata = dmem_store;
          req_d.be    = dbe;
          req_d.wr    = dmem_wen;
          err_d       = 1'b0;
        end else if (imem_ren) begin
          state_d     = IREQ;
          req_d.addr  = {imem_addr[31:2], 2'b00};
          req_d.wdata = '0;
          req_d.be    = 4'b1111;
          req_d.wr    = 1'b0;
          err_d       = 1'b0;
        end
      end
      DREQ, IREQ: begin
        if (ram_ready) begin
          state_d = (state_q == DREQ) ? DRESP : IRESP;
          load_d  = req_q.wr ? 32'h0 : ram_rdata;  // stores answer with 0
        end else if (tmo) begin
          state_d = (state_q == DREQ) ? DRESP : IRESP;
          load_d  = '0;
          err_d   = 1'b1;
        end
      end
      // The requester still holds its request through this edge, so it is
      // not sampled here; that is what enforces the 3-cycle hit spacing.
      DRESP, IRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  assign ram_ren    = in_req && !req_q.wr;
  assign ram_wen    = in_req && req_q.wr;
  assign ram_addr   = req_q.addr;
  assign ram_byteen = req_q.be;
  assign ram_wdata  = req_q.wdata;

  assign ihit      = (state_q == IRESP);
  assign dhit      = (state_q == DRESP);
  assign imem_load = load_q;
  assign dmem_load = load_q;
  assign bus_err   = err_q && (ihit || dhit);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_ren, ihit;
  logic [31:0] imem_addr, imem_load;
  logic        dmem_ren, dmem_wen, dhit;
  logic [31:0] dmem_addr, dmem_store, dmem_load;
  logic [2:0]  dmem_width;
  logic        ram_ren, ram_wen, ram_ready, bus_err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_byteen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .ihit(ihit), .imem_load(imem_load),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_width(dmem_width), .dmem_store(dmem_store), .dhit(dhit), .dmem_load(dmem_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] addr;
    logic [2:0]  width;
    logic [31:0] store, rdata;
    int          dly;
    bit          drop;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
  endtask

  // Request presented in cycle 0; strobe checked in cycle 1; ready given in
  // cycle 1+dly; hit expected in cycle 2+dly only.
  task automatic run_vec(input vec_t v, input int idx);
    int early = 0;
    int bad_strobe = 0;
    @(negedge clk);
    imem_ren = v.iren; imem_addr = v.addr;
    dmem_ren = v.dren; dmem_wen = v.dwen; dmem_addr = v.addr;
    dmem_width = v.width; dmem_store = v.store; ram_rdata = v.rdata;
    for (int c = 1; c <= 2 + v.dly; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d ram_ren", idx), 32'(ram_ren), 32'(!v.exp_wr));
        chk($sformatf("v%0d ram_wen", idx), 32'(ram_wen), 32'(v.exp_wr));
        chk($sformatf("v%0d ram_addr", idx), ram_addr, v.exp_addr);
        chk($sformatf("v%0d ram_byteen", idx), 32'(ram_byteen), 32'(v.exp_be));
        chk($sformatf("v%0d ram_wdata", idx), ram_wdata, v.exp_wdata);
        if (v.drop) clear_req();
      end
      if (c <= 1 + v.dly) begin
        if (ram_ren !== !v.exp_wr || ram_wen !== v.exp_wr) bad_strobe++;
        if (ihit || dhit) early++;
      end
      if (c == 1 + v.dly) ram_ready = 1;
      if (c == 2 + v.dly) begin
        chk($sformatf("v%0d ihit", idx), 32'(ihit), 32'(v.iren && !v.dren && !v.dwen));
        chk($sformatf("v%0d dhit", idx), 32'(dhit), 32'(v.dren || v.dwen));
        chk($sformatf("v%0d load", idx), v.iren ? imem_load : dmem_load, v.exp_load);
        chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'h0);
        chk($sformatf("v%0d strobe off", idx), 32'(ram_ren | ram_wen), 32'h0);
        ram_ready = 0;
        clear_req();
      end
    end
    chk($sformatf("v%0d early hit", idx), 32'(early), 32'h0);
    chk($sformatf("v%0d strobe held", idx), 32'(bad_strobe), 32'h0);
  endtask

  initial begin
    int dcyc, icyc, both, hits, bad;
    // iren dren dwen addr width store rdata dly drop | wr addr be wdata load
    vecs[0] = '{1, 0, 0, 32'h100, 3'b010, 32'h0, 32'h00000013, 0, 0,
                0, 32'h100, 4'b1111, 32'h0, 32'h00000013};
    vecs[1] = '{0, 0, 1, 32'h203, 3'b000, 32'hAB000000, 32'h55555555, 0, 0,
                1, 32'h200, 4'b1000, 32'hAB000000, 32'h0};
    vecs[2] = '{0, 1, 0, 32'h302, 3'b001, 32'h0, 32'h80011234, 3, 0,
                0, 32'h300, 4'b1100, 32'h0, 32'h80011234};
    vecs[3] = '{0, 1, 0, 32'h404, 3'b010, 32'h0, 32'hDEADBEEF, 1, 1,
                0, 32'h404, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[4] = '{0, 1, 0, 32'h501, 3'b100, 32'h0, 32'h11223344, 0, 0,
                0, 32'h500, 4'b0010, 32'h0, 32'h11223344};
    vecs[5] = '{0, 0, 1, 32'h600, 3'b001, 32'h0000BEEF, 32'h0, 2, 0,
                1, 32'h600, 4'b0011, 32'h0000BEEF, 32'h0};
    vecs[6] = '{0, 1, 1, 32'h707, 3'b011, 32'h12345678, 32'hFFFFFFFF, 0, 0,
                1, 32'h704, 4'b1111, 32'h12345678, 32'h0};
    vecs[7] = '{1, 0, 0, 32'h103, 3'b000, 32'h0, 32'hCAFEF00D, 1, 1,
                0, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D};

    nrst = 0; clear_req();
    imem_addr = 0; dmem_addr = 0; dmem_width = 0; dmem_store = 0;
    ram_rdata = 0; ram_ready = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst ihit", 32'(ihit), 32'h0);
    chk("rst dhit", 32'(dhit), 32'h0);
    chk("rst imem_load", imem_load, 32'h0);
    chk("rst dmem_load", dmem_load, 32'h0);
    chk("rst ram_ren", 32'(ram_ren), 32'h0);
    chk("rst ram_wen", 32'(ram_wen), 32'h0);
    chk("rst ram_addr", ram_addr, 32'h0);
    chk("rst ram_byteen", 32'(ram_byteen), 32'h0);
    chk("rst ram_wdata", ram_wdata, 32'h0);
    chk("rst bus_err", 32'(bus_err), 32'h0);
    nrst = 1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous fetch and load with a 1-cycle RAM: data first, ihit 3 later.
    @(negedge clk);
    imem_ren = 1; imem_addr = 32'h800;
    dmem_ren = 1; dmem_addr = 32'h900; dmem_width = 3'b010;
    ram_ready = 1; ram_rdata = 32'h11110000;
    dcyc = -1; icyc = -1; both = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("sim first addr", ram_addr, 32'h900);
      if (ihit && dhit) both++;
      if (dhit) begin
        dcyc = c; dmem_ren = 0;
        chk("sim dmem_load", dmem_load, 32'h11110000);
        ram_rdata = 32'h22220000;
      end
      if (ihit) begin
        icyc = c; imem_ren = 0;
        chk("sim imem_load", imem_load, 32'h22220000);
      end
    end
    ram_ready = 0;
    chk("sim dhit cycle", 32'(dcyc), 32'd2);
    chk("sim ihit cycle", 32'(icyc), 32'd5);
    chk("sim both hits", 32'(both), 32'h0);

    // Reset in the middle of a stalled load.
    @(negedge clk);
    dmem_ren = 1; dmem_addr = 32'hA00; dmem_width = 3'b010;
    @(negedge clk);
    chk("rstmid ram_ren before", 32'(ram_ren), 32'h1);
    #2 nrst = 0;
    #1 chk("rstmid ram_ren async", 32'(ram_ren), 32'h0);
    clear_req();
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) nrst = 1;
      if (dhit || ihit) hits++;
    end
    chk("rstmid no hit", 32'(hits), 32'h0);
    run_vec(vecs[0], 8);

    // RAM never ready.
    @(negedge clk);
    dmem_ren = 1; dmem_addr = 32'hB00; dmem_width = 3'b010; ram_rdata = 32'hFFFFFFFF;
    bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
      if (c == 9) begin
        chk("tmo dhit", 32'(dhit), 32'h1);
        chk("tmo bus_err", 32'(bus_err), 32'h1);
        chk("tmo dmem_load", dmem_load, 32'h0);
        dmem_ren = 0;
      end else if (dhit || ihit || bus_err) bad++;
`else
      if (dhit || ihit || bus_err) bad++;
      if (c == 12) chk("stall ram_ren held", 32'(ram_ren), 32'h1);
`endif
    end
    chk("stall stray hit/err", 32'(bad), 32'h0);
    clear_req();
    nrst = 0;
    @(negedge clk);
    nrst = 1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
